tx_frame_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares one serial `transmission` line among NUM_REQ requesters. It feeds the `rx` block's input.
- Each granted requester gets one 8-bit frame: start bit 0, 8 data bits LSB-first, stop bit 1.
- Each bit is held for BIT_TICKS clocks.
- Line idles high.

---
 rtl/tx_frame_arbiter.sv | 126 ++++++++++++
 tb/tb_tx_frame_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that serialises one 8-bit frame per grant onto a shared line.
// Frame format: start 0, 8 data bits LSB-first, stop 1, each bit held BIT_TICKS clocks.
//
//   state   | meaning
//   S_IDLE  | line high, waiting for any request
//   S_START | start bit (low)
//   S_DATA  | payload bits, LSB first
//   S_STOP  | stop bit (high), frame counted on its last edge
module tx_frame_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_TICKS = 1,
  parameter int GID_W     = 2
) (
  input  logic                 clk2,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 transmission,
  output logic                 busy,
  output logic [GID_W-1:0]     grant_id,
  output logic [7:0]           frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [7:0]     TICK_LAST = 8'(BIT_TICKS - 1);
  localparam logic [GID_W:0] NREQ_W    = (GID_W+1)'(NUM_REQ);

  state_t           r_state;
  logic [7:0]       r_tick;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [GID_W-1:0] r_last_grant;

  logic             w_tick_done;
  logic             w_found;
  logic [GID_W-1:0] w_sel;
  logic [GID_W:0]   w_cand;

  assign w_tick_done = (r_tick == TICK_LAST);

  // Scan upward from the requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last_grant} + (GID_W+1)'(k);
      if (w_cand >= NREQ_W) w_cand = w_cand - NREQ_W;
      if (!w_found && req[w_cand[GID_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[GID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_last_grant <= GID_W'(NUM_REQ - 1);
      ack          <= '0;
      transmission <= 1'b1;
      busy         <= 1'b0;
      grant_id     <= '0;
      frames_sent  <= '0;
    end else begin
      ack <= '0;
      case (r_state)
        S_IDLE: begin
          transmission <= 1'b1;
          busy         <= 1'b0;
          r_tick       <= '0;
          if (w_found) begin
            r_shift      <= data_in[{w_sel, 3'b000} +: 8];
            grant_id     <= w_sel;
            r_last_grant <= w_sel;
            ack[w_sel]   <= 1'b1;
            transmission <= 1'b0;
            busy         <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          if (w_tick_done) begin
            r_tick       <= '0;
            r_bit        <= '0;
            transmission <= r_shift[0];
            r_state      <= S_DATA;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        S_DATA: begin
          if (w_tick_done) begin
            r_tick <= '0;
            if (r_bit == 3'd7) begin
              transmission <= 1'b1;
              r_state      <= S_STOP;
            end else begin
              r_bit        <= r_bit + 3'd1;
              transmission <= r_shift[r_bit + 3'd1];
            end
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        S_STOP: begin
          if (w_tick_done) begin
            r_tick      <= '0;
            frames_sent <= frames_sent + 8'd1;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: stimulus queues expected frames,
// per-instance monitors decode the serial line against them.
module tb_tx_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic [3:0]  req1, req3;
  logic [31:0] data1, data3;
  logic [3:0]  ack1, ack3;
  logic        tx1, tx3, busy1, busy3;
  logic [1:0]  gid1, gid3;
  logic [7:0]  fs1, fs3;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic [7:0] fs;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   gt1[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   done1 = 0;
  int   done3 = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_frame_arbiter #(.NUM_REQ(4), .BIT_TICKS(1), .GID_W(2)) dut1 (
    .clk2(clk), .rst(rst1), .req(req1), .data_in(data1), .ack(ack1),
    .transmission(tx1), .busy(busy1), .grant_id(gid1), .frames_sent(fs1));

  tx_frame_arbiter #(.NUM_REQ(4), .BIT_TICKS(3), .GID_W(2)) dut3 (
    .clk2(clk), .rst(rst3), .req(req3), .data_in(data3), .ack(ack3),
    .transmission(tx3), .busy(busy3), .grant_id(gid3), .frames_sent(fs3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] f_ack(int u);  return (u == 0) ? ack1  : ack3;  endfunction
  function automatic logic       f_tx(int u);   return (u == 0) ? tx1   : tx3;   endfunction
  function automatic logic       f_busy(int u); return (u == 0) ? busy1 : busy3; endfunction
  function automatic logic [1:0] f_gid(int u);  return (u == 0) ? gid1  : gid3;  endfunction
  function automatic logic [7:0] f_fs(int u);   return (u == 0) ? fs1   : fs3;   endfunction
  function automatic logic       f_rst(int u);  return (u == 0) ? rst1  : rst3;  endfunction

  task automatic monitor(input int u, input int bt);
    exp_t e;
    bit   abort;
    logic exp_bit;
    int   qsz;
    forever begin
      @(negedge clk);
      if (f_rst(u) || f_ack(u) == 4'b0) continue;
      if (u == 0) gt1.push_back(cyc);
      qsz = (u == 0) ? q1.size() : q3.size();
      if (qsz == 0) begin
        chk("unexpected_ack", 32'(f_ack(u)), 32'd0);
        continue;
      end
      e = (u == 0) ? q1.pop_front() : q3.pop_front();
      chk("ack_onehot", 32'(f_ack(u)), 32'(4'b0001 << e.id));
      chk("grant_id", 32'(f_gid(u)), 32'(e.id));
      chk("busy_in_frame", 32'(f_busy(u)), 32'd1);
      abort = 1'b0;
      for (int b = 0; b < 10 && !abort; b++) begin
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[3'(b - 1)];
        for (int t = 0; t < bt && !abort; t++) begin
          if (b > 0 || t > 0) begin
            @(negedge clk);
            if (f_rst(u)) begin
              abort = 1'b1;
              break;
            end
            chk("ack_single_cycle", 32'(f_ack(u)), 32'd0);
          end
          chk("tx_bit", 32'(f_tx(u)), 32'(exp_bit));
        end
      end
      if (!abort) begin
        @(negedge clk);
        if (!f_rst(u)) begin
          chk("busy_after_frame", 32'(f_busy(u)), 32'd0);
          chk("tx_idle_high", 32'(f_tx(u)), 32'd1);
          chk("frames_sent", 32'(f_fs(u)), 32'(e.fs));
          if (u == 0) done1++; else done3++;
        end
      end
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 3);

  task automatic wait_done(input int u, input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (((u == 0) ? done1 : done3) >= target) break;
    end
    chk("frames_done", 32'((u == 0) ? done1 : done3), 32'(target));
  endtask

  task automatic wait_ack1(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack1 != 4'b0) break;
    end
    chk("ack_seen", 32'(ack1 != 4'b0), 32'd1);
  endtask

  task automatic push1(input logic [1:0] id, input logic [7:0] d, input logic [7:0] fs);
    exp_t e;
    e.id = id; e.data = d; e.fs = fs;
    q1.push_back(e);
  endtask

  initial begin
    int acks;
    exp_t e;
    rst1 = 1'b0; rst3 = 1'b0;
    req1 = 4'hF; req3 = 4'h0;
    data1 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    data3 = 32'h0;
    #1;
    rst1 = 1'b1; rst3 = 1'b1;

    // reset held with every requester asking
    repeat (4) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx1), 32'd1);
      chk("rst_ack", 32'(ack1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_gid", 32'(gid1), 32'd0);
      chk("rst_fs", 32'(fs1), 32'd0);
      chk("rst_tx3", 32'(tx3), 32'd1);
    end

    // round robin with all four requesting
    push1(2'd0, 8'hA0, 8'd1);
    push1(2'd1, 8'hA1, 8'd2);
    push1(2'd2, 8'hA2, 8'd3);
    push1(2'd3, 8'hA3, 8'd4);
    push1(2'd0, 8'hA0, 8'd5);
    rst1 = 1'b0;
    acks = 0;
    for (int i = 0; i < 100 && acks < 5; i++) begin
      @(negedge clk);
      if (ack1 != 4'b0) acks++;
    end
    req1 = 4'h0;
    chk("rr_acks", 32'(acks), 32'd5);
    wait_done(0, 5, 100);
    chk("rr_grant_count", 32'(gt1.size()), 32'd5);
    for (int i = 1; i < 5 && i < gt1.size(); i++)
      chk("rr_spacing", 32'(gt1[i] - gt1[i-1]), 32'd11);
    chk("rr_fs5", 32'(fs1), 32'd5);

    // single frame, payload changes after grant must not leak in
    push1(2'd1, 8'h93, 8'd6);
    data1[15:8] = 8'h93;
    req1 = 4'b0010;
    wait_ack1(20);
    req1 = 4'b0000;
    data1[15:8] = 8'hFF;
    wait_done(0, 6, 40);
    chk("hold_gid", 32'(gid1), 32'd1);

    // reset during data bit 4
    push1(2'd2, 8'hA5, 8'd0);
    data1[23:16] = 8'hA5;
    req1 = 4'b0100;
    wait_ack1(20);
    repeat (5) @(negedge clk);
    chk("mid_bit4", 32'(tx1), 32'd0);
    #1 rst1 = 1'b1;
    #1;
    chk("async_tx", 32'(tx1), 32'd1);
    chk("async_busy", 32'(busy1), 32'd0);
    chk("async_fs", 32'(fs1), 32'd0);
    chk("async_gid", 32'(gid1), 32'd0);
    repeat (2) @(negedge clk);
    push1(2'd2, 8'hA5, 8'd1);
    rst1 = 1'b0;
    wait_ack1(20);
    req1 = 4'b0000;
    wait_done(0, 7, 40);

    // 256 frames to wrap the counter
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 256; k++) push1(2'd0, 8'hC3, 8'((k + 1) % 256));
    data1[7:0] = 8'hC3;
    req1 = 4'b0001;
    rst1 = 1'b0;
    acks = 0;
    for (int i = 0; i < 256 * 11 + 50 && acks < 256; i++) begin
      @(negedge clk);
      if (ack1 != 4'b0) acks++;
    end
    req1 = 4'b0000;
    chk("wrap_acks", 32'(acks), 32'd256);
    wait_done(0, 7 + 256, 40);
    chk("wrap_fs", 32'(fs1), 32'd0);

    // three ticks per bit, payload 01
    e.id = 2'd0; e.data = 8'h01; e.fs = 8'd1;
    q3.push_back(e);
    data3[7:0] = 8'h01;
    @(negedge clk);
    rst3 = 1'b0;
    req3 = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack3 != 4'b0) break;
    end
    req3 = 4'b0000;
    wait_done(1, 1, 60);

    repeat (3) @(negedge clk);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q3_empty", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
